// File: rtl/buffer_controller_if.sv
// Request/grant signals between the frame writer/reader and the triple-buffer
// ownership manager.
interface buffer_controller_if;
   logic       write_rq_rdy;
   logic       finalize_wr;
   logic       read_rq_rdy;
   logic       finalize_rd;
   logic       buffer_id_valid;
   logic [1:0] buffer_id;

   modport master (
      output write_rq_rdy, finalize_wr, read_rq_rdy, finalize_rd,
      input  buffer_id_valid, buffer_id
   );

   modport slave (
      input  write_rq_rdy, finalize_wr, read_rq_rdy, finalize_rd,
      output buffer_id_valid, buffer_id
   );
endinterface

// File: rtl/buffer_controller.sv
// Triple-buffer ownership manager: grants the writer a buffer that is neither
// being read nor the newest frame, and always hands the reader the newest frame.
module buffer_controller #(
   parameter int NUM_BUFFERS = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   buffer_controller_if.slave  bus
);

   logic       wr_rq_prev_r, fin_wr_prev_r, rd_rq_prev_r, fin_rd_prev_r;
   logic [1:0] writing_idx_r, reading_idx_r, latest_idx_r, buffer_id_r;
   logic       writing_active_r, reading_active_r, latest_valid_r;
   logic       rd_pending_r, buffer_id_valid_r;

   logic       wr_ev_s, fin_wr_ev_s, rd_ev_s, fin_rd_ev_s, rd_want_s;
   logic [1:0] writing_idx_s, reading_idx_s, latest_idx_s, buffer_id_s;
   logic       writing_active_s, reading_active_s, latest_valid_s;
   logic       rd_pending_s, buffer_id_valid_s;

   // Lowest buffer index not matching either enabled exclusion.
   function automatic logic [1:0] lowest_free(
      input logic       ex_a_en,
      input logic [1:0] ex_a,
      input logic       ex_b_en,
      input logic [1:0] ex_b
   );
      logic [1:0] pick;
      logic       found;
      pick  = 2'd0;
      found = 1'b0;
      for (int i = 0; i < NUM_BUFFERS; i++) begin
         if (!found && !(ex_a_en && ex_a == 2'(i)) && !(ex_b_en && ex_b == 2'(i))) begin
            pick  = 2'(i);
            found = 1'b1;
         end else begin
            pick = pick;
         end
      end
      return pick;
   endfunction

   // Next-state: finalizes apply first, then a write grant takes priority over a read.
   always_comb begin
      wr_ev_s     = bus.write_rq_rdy & ~wr_rq_prev_r;
      fin_wr_ev_s = bus.finalize_wr  & ~fin_wr_prev_r;
      rd_ev_s     = bus.read_rq_rdy  & ~rd_rq_prev_r;
      fin_rd_ev_s = bus.finalize_rd  & ~fin_rd_prev_r;

      writing_idx_s     = writing_idx_r;
      writing_active_s  = writing_active_r;
      reading_idx_s     = reading_idx_r;
      reading_active_s  = reading_active_r;
      latest_idx_s      = latest_idx_r;
      latest_valid_s    = latest_valid_r;
      buffer_id_s       = buffer_id_r;
      buffer_id_valid_s = 1'b0;
      rd_pending_s      = 1'b0;

      if (fin_wr_ev_s && writing_active_r) begin
         latest_idx_s     = writing_idx_r;
         latest_valid_s   = 1'b1;
         writing_active_s = 1'b0;
      end else begin
         writing_active_s = writing_active_r;
      end

      if (fin_rd_ev_s) begin
         reading_active_s = 1'b0;
      end else begin
         reading_active_s = reading_active_r;
      end

      rd_want_s = rd_ev_s | rd_pending_r;

      // A read colliding with a write grant is deferred by one cycle.
      if (wr_ev_s) begin
         buffer_id_s       = lowest_free(reading_active_s, reading_idx_r,
                                         latest_valid_s, latest_idx_s);
         writing_idx_s     = buffer_id_s;
         writing_active_s  = 1'b1;
         buffer_id_valid_s = 1'b1;
         rd_pending_s      = rd_want_s;
      end else if (rd_want_s) begin
         if (latest_valid_s) begin
            buffer_id_s = latest_idx_s;
         end else begin
            buffer_id_s = lowest_free(writing_active_s, writing_idx_r, 1'b0, 2'd0);
         end
         reading_idx_s     = buffer_id_s;
         reading_active_s  = 1'b1;
         buffer_id_valid_s = 1'b1;
      end else begin
         buffer_id_valid_s = 1'b0;
      end
   end

   // State, edge-detect history and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_rq_prev_r      <= 1'b0;
         fin_wr_prev_r     <= 1'b0;
         rd_rq_prev_r      <= 1'b0;
         fin_rd_prev_r     <= 1'b0;
         writing_idx_r     <= 2'd0;
         writing_active_r  <= 1'b0;
         reading_idx_r     <= 2'd0;
         reading_active_r  <= 1'b0;
         latest_idx_r      <= 2'd0;
         latest_valid_r    <= 1'b0;
         rd_pending_r      <= 1'b0;
         buffer_id_r       <= 2'd0;
         buffer_id_valid_r <= 1'b0;
      end else begin
         wr_rq_prev_r      <= bus.write_rq_rdy;
         fin_wr_prev_r     <= bus.finalize_wr;
         rd_rq_prev_r      <= bus.read_rq_rdy;
         fin_rd_prev_r     <= bus.finalize_rd;
         writing_idx_r     <= writing_idx_s;
         writing_active_r  <= writing_active_s;
         reading_idx_r     <= reading_idx_s;
         reading_active_r  <= reading_active_s;
         latest_idx_r      <= latest_idx_s;
         latest_valid_r    <= latest_valid_s;
         rd_pending_r      <= rd_pending_s;
         buffer_id_r       <= buffer_id_s;
         buffer_id_valid_r <= buffer_id_valid_s;
      end
   end

   assign bus.buffer_id_valid = buffer_id_valid_r;
   assign bus.buffer_id       = buffer_id_r;

endmodule

// File: tb/tb_buffer_controller.sv
// Scoreboard bench for buffer_controller: a set-based reference model queues
// expected grants; a monitor matches every valid pulse against the queue.
module tb_buffer_controller;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   buffer_controller_if bus();

   buffer_controller #(.NUM_BUFFERS(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [1:0] id;
   } exp_t;
   exp_t exp_q[$];

   // Reference model: owners as plain integers, -1 meaning "nobody".
   int m_writing, m_reading, m_latest;
   bit m_pend;
   bit p_wr, p_fw, p_rd, p_fr;
   logic [1:0] mon_last_id = 2'd0;

   function automatic int first_free(input int a, input int b);
      for (int i = 0; i < 3; i++)
         if (i != a && i != b) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_writing = -1; m_reading = -1; m_latest = -1; m_pend = 1'b0;
      p_wr = 1'b0; p_fw = 1'b0; p_rd = 1'b0; p_fr = 1'b0;
   endtask

   task automatic model_step(input bit wr, input bit fw, input bit rd, input bit fr, input int k);
      bit ew, efw, erd, efr, want_rd;
      int id;
      ew = wr && !p_wr; efw = fw && !p_fw; erd = rd && !p_rd; efr = fr && !p_fr;
      p_wr = wr; p_fw = fw; p_rd = rd; p_fr = fr;
      if (efw && m_writing >= 0) begin
         m_latest  = m_writing;
         m_writing = -1;
      end
      if (efr) m_reading = -1;
      want_rd = erd || m_pend;
      m_pend = 1'b0;
      if (ew) begin
         id = first_free(m_reading, m_latest);
         m_writing = id;
         exp_q.push_back('{k, 2'(id)});
         m_pend = want_rd;
      end else if (want_rd) begin
         id = (m_latest >= 0) ? m_latest : first_free(m_writing, -1);
         m_reading = id;
         exp_q.push_back('{k, 2'(id)});
      end
   endtask

   task automatic step(input bit wr, input bit fw, input bit rd, input bit fr);
      @(negedge clk);
      bus.write_rq_rdy = wr; bus.finalize_wr = fw;
      bus.read_rq_rdy  = rd; bus.finalize_rd = fr;
      model_step(wr, fw, rd, fr, cyc + 1);
   endtask

   task automatic apply_reset();
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: sample after each active edge and reconcile against the queue.
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         checks++;
         if (bus.buffer_id_valid !== 1'b0 || bus.buffer_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs cyc=%0d valid=%b id=%0d required valid=0 id=0",
                     cyc, bus.buffer_id_valid, bus.buffer_id);
         end
         mon_last_id = 2'd0;
      end else begin
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL missing_grant cyc=%0d no pulse, required id=%0d at cyc=%0d",
                     cyc, exp_q[0].id, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
         if (bus.buffer_id_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
               errors++;
               $display("FAIL unexpected_grant cyc=%0d id=%0d required no pulse",
                        cyc, bus.buffer_id);
            end else begin
               if (bus.buffer_id !== exp_q[0].id) begin
                  errors++;
                  $display("FAIL grant_id cyc=%0d id=%0d required %0d",
                           cyc, bus.buffer_id, exp_q[0].id);
               end
               mon_last_id = exp_q[0].id;
               void'(exp_q.pop_front());
            end
         end else if (bus.buffer_id_valid === 1'b0) begin
            checks++;
            if (bus.buffer_id !== mon_last_id) begin
               errors++;
               $display("FAIL id_hold cyc=%0d id=%0d required %0d",
                        cyc, bus.buffer_id, mon_last_id);
            end
         end else begin
            checks++; errors++;
            $display("FAIL valid_x cyc=%0d valid=%b required 0 or 1", cyc, bus.buffer_id_valid);
         end
      end
   end

   // Directed scenarios as {wr, fw, rd, fr} per cycle.
   logic [3:0] dir_seq [] = '{
      4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000,
      4'b0010, 4'b0000, 4'b0001, 4'b0000,
      4'b0100, 4'b0000, 4'b0010, 4'b0010, 4'b1000, 4'b1000,
      4'b0100, 4'b1000, 4'b0000, 4'b0100, 4'b1000, 4'b0000,
      4'b0001, 4'b0010, 4'b0000, 4'b0000
   };

   initial begin
      bus.write_rq_rdy = 1'b0; bus.finalize_wr = 1'b0;
      bus.read_rq_rdy  = 1'b0; bus.finalize_rd = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      foreach (dir_seq[i]) step(dir_seq[i][3], dir_seq[i][2], dir_seq[i][1], dir_seq[i][0]);

      // Simultaneous write and read edges from reset.
      apply_reset();
      step(1'b1, 1'b0, 1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

      // Finalize with no active write, then a read.
      apply_reset();
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

      // Reset lands between a request edge and its grant: no pulse afterwards.
      repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      bus.write_rq_rdy = 1'b1;
      #2 rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      bus.write_rq_rdy = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);

      // Randomized traffic: each input toggles with probability 1/4 per cycle.
      for (int n = 0; n < 600; n++) begin
         bit wr, fw, rd, fr;
         wr = bus.write_rq_rdy ^ ($urandom_range(0, 3) == 0);
         fw = bus.finalize_wr  ^ ($urandom_range(0, 3) == 0);
         rd = bus.read_rq_rdy  ^ ($urandom_range(0, 3) == 0);
         fr = bus.finalize_rd  ^ ($urandom_range(0, 3) == 0);
         step(wr, fw, rd, fr);
         if (n == 300) apply_reset();
      end

      repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_queue outstanding=%0d required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
